sprite_line_scheduler: RTL



---
 rtl/sprite_pkg.sv | 27 ++
 rtl/sprite_list_buf.sv | 72 +++++++
 rtl/sprite_line_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// ============================================================================
// Module  : sprite_pkg
// Brief   : Shared constants and FSM state encoding for the sprite scheduler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int OBJ_BYTES        = 4;
    localparam int OBJ_X            = 0;
    localparam int OBJ_Y            = 1;
    localparam int OBJ_BMP          = 2;
    localparam int OBJ_SIZE         = 3;
    localparam int MAX_SPRITES_DFLT = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_Y  = 3'd1,
        ST_RD_SZ = 3'd2,
        ST_EVAL  = 3'd3,
        ST_SWAP  = 3'd4
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/sprite_list_buf.sv
// ============================================================================
// Module  : sprite_list_buf
// Brief   : Double-buffered sprite index list; back bank written, front read.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_list_buf #(
    parameter int LIST_DEPTH = 4,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [IDX_W-1:0] push_idx_i,
    input  logic             swap_i,
    input  logic [IDX_W-1:0] rd_sel_i,
    output logic [IDX_W-1:0] rd_entry_o,
    output logic [IDX_W:0]   front_count_o,
    output logic             full_o
);
    import sprite_pkg::*;

    logic             sel_q;
    logic [IDX_W-1:0] list_q [2][LIST_DEPTH];
    logic [IDX_W:0]   cnt_q  [2];
    logic             w_back;

    assign w_back        = ~sel_q;
    assign front_count_o = cnt_q[sel_q];
    assign full_o        = (cnt_q[w_back] == (IDX_W+1)'(LIST_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= '0;
                for (int k = 0; k < LIST_DEPTH; k++) begin
                    list_q[b][k] <= '0;
                end
            end
        end else begin
            if (clear_i) begin
                cnt_q[w_back] <= '0;
            end else if (push_i) begin
                for (int k = 0; k < LIST_DEPTH; k++) begin
                    if (cnt_q[w_back] == (IDX_W+1)'(k)) begin
                        list_q[w_back][k] <= push_idx_i;
                    end
                end
                cnt_q[w_back] <= cnt_q[w_back] + 1'b1;
            end
            if (swap_i) begin
                sel_q <= ~sel_q;
            end
        end
    end

    // Out-of-range selects return zero; the renderer never reads past the count.
    always_comb begin
        rd_entry_o = '0;
        for (int k = 0; k < LIST_DEPTH; k++) begin
            if (rd_sel_i == IDX_W'(k)) begin
                rd_entry_o = list_q[sel_q][k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_line_scheduler.sv
// ============================================================================
// Module  : sprite_line_scheduler
// Brief   : Per-scanline object table scan building a double-buffered hit list.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sprite_line_scheduler #(
    parameter int MAX_SPRITES = sprite_pkg::MAX_SPRITES_DFLT,
    parameter int OBJ_BYTES   = sprite_pkg::OBJ_BYTES,
    parameter int LIST_DEPTH  = 4,
    parameter int IDX_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_start_i,
    input  logic [7:0]       next_line_i,
    output logic [5:0]       obj_addr_o,
    input  logic [7:0]       obj_rdata_i,
    input  logic             host_req_i,
    input  logic [5:0]       host_addr_i,
    output logic             host_gnt_o,
    output logic             host_rvalid_o,
    output logic [7:0]       host_rdata_o,
    input  logic [IDX_W-1:0] list_sel_i,
    output logic [IDX_W-1:0] list_entry_o,
    output logic [IDX_W:0]   list_count_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             overflow_o,
    output logic             late_o,
    input  logic             clr_status_i
);
    import sprite_pkg::*;

    localparam int ADDR_W = 6;

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       line_q, line_d;
    logic [7:0]       y_q, y_d;
    logic             overflow_q, late_q;
    logic             host_rvalid_q;
    logic [7:0]       host_hold_q;

    logic             w_push, w_clear, w_swap, w_ovf_set, w_late_set;
    logic             w_full, w_hit, w_host_slot;
    logic [8:0]       w_y_end;
    logic [5:0]       w_base;

    // 9-bit extent so a sprite near the bottom never wraps to the top lines.
    assign w_y_end = {1'b0, y_q} + {5'd0, obj_rdata_i[3:0]} + 9'd1;
    assign w_hit   = (line_q >= y_q) && ({1'b0, line_q} < w_y_end);
    assign w_base  = ADDR_W'(idx_q) * ADDR_W'(OBJ_BYTES);

    assign w_host_slot = (state_q == ST_IDLE) || (state_q == ST_SWAP);
    assign host_gnt_o  = rst_n && host_req_i && w_host_slot && !line_start_i;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_SWAP) && !line_start_i;
    assign overflow_o  = overflow_q;
    assign late_o      = late_q;
    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rvalid_q ? obj_rdata_i : host_hold_q;

    always_comb begin
        obj_addr_o = '0;
        case (state_q)
            ST_RD_Y:  obj_addr_o = w_base + ADDR_W'(OBJ_Y);
            ST_RD_SZ: obj_addr_o = w_base + ADDR_W'(OBJ_SIZE);
            default:  if (host_gnt_o) obj_addr_o = host_addr_i;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        line_d     = line_q;
        y_d        = y_q;
        w_push     = 1'b0;
        w_clear    = 1'b0;
        w_swap     = 1'b0;
        w_ovf_set  = 1'b0;
        w_late_set = 1'b0;
        if (line_start_i) begin
            // A pulse mid-scan discards the partial back list and restarts.
            line_d     = next_line_i;
            idx_d      = '0;
            w_clear    = 1'b1;
            w_late_set = (state_q != ST_IDLE);
            state_d    = ST_RD_Y;
        end else begin
            case (state_q)
                ST_RD_Y:  state_d = ST_RD_SZ;
                ST_RD_SZ: begin
                    y_d     = obj_rdata_i;
                    state_d = ST_EVAL;
                end
                ST_EVAL: begin
                    if (w_hit) begin
                        w_push    = !w_full;
                        w_ovf_set = w_full;
                    end
                    if (idx_q == IDX_W'(MAX_SPRITES - 1)) begin
                        state_d = ST_SWAP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RD_Y;
                    end
                end
                ST_SWAP: begin
                    w_swap  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            line_q        <= '0;
            y_q           <= '0;
            overflow_q    <= 1'b0;
            late_q        <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_hold_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            line_q        <= line_d;
            y_q           <= y_d;
            overflow_q    <= w_ovf_set  ? 1'b1 : (clr_status_i ? 1'b0 : overflow_q);
            late_q        <= w_late_set ? 1'b1 : (clr_status_i ? 1'b0 : late_q);
            host_rvalid_q <= host_gnt_o;
            if (host_rvalid_q) begin
                host_hold_q <= obj_rdata_i;
            end
        end
    end

    sprite_list_buf #(
        .LIST_DEPTH (LIST_DEPTH),
        .IDX_W      (IDX_W)
    ) u_list (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (w_clear),
        .push_i        (w_push),
        .push_idx_i    (idx_q),
        .swap_i        (w_swap),
        .rd_sel_i      (list_sel_i),
        .rd_entry_o    (list_entry_o),
        .front_count_o (list_count_o),
        .full_o        (w_full)
    );

endmodule

`default_nettype wire
